// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared types and constants for the proc2mem / mem2proc bus.
//   BUS_NONE/BUS_LOAD/BUS_STORE : 2-bit command encodings (2'b11 reserved).
//   tag_t                       : 4-bit transaction tag, 0 means "none".
//   q_entry_t                   : outstanding-request record {tag, data, countdown}.
package mem_bus_pkg;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 4;
  localparam int CD_W   = 4;

  localparam logic [1:0] BUS_NONE  = 2'b00;
  localparam logic [1:0] BUS_LOAD  = 2'b01;
  localparam logic [1:0] BUS_STORE = 2'b10;

  typedef logic [TAG_W-1:0] tag_t;

  typedef struct packed {
    tag_t              tag;
    logic [DATA_W-1:0] data;
    logic [CD_W-1:0]   countdown;
  } q_entry_t;

  // Round-robin tag allocation over 1..15; 0 is reserved for "no tag".
  function automatic tag_t tag_next(input tag_t t);
    return (t == tag_t'(15)) ? tag_t'(1) : t + tag_t'(1);
  endfunction
endpackage

// File: rtl/mem_resp_queue.sv
// mem_resp_queue: in-order circular FIFO of outstanding requests.
// Each entry carries a countdown loaded with LATENCY-1 on push; the head
// pops on the edge where its countdown is already 0, i.e. exactly LATENCY
// edges after the push edge.
//   clk, rst_n          : clock, async active-low reset
//   push_vld/tag/data   : enqueue (caller guarantees !full)
//   full                : count == DEPTH (pre-edge)
//   pop_vld/tag/data    : head completes at the coming edge
module mem_resp_queue
  import mem_bus_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_vld,
  input  tag_t              push_tag,
  input  logic [DATA_W-1:0] push_data,
  output logic              full,
  output logic              pop_vld,
  output tag_t              pop_tag,
  output logic [DATA_W-1:0] pop_data
);
  localparam int              PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST   = PTR_W'(DEPTH - 1);
  localparam logic [4:0]      DEPTH_C = 5'(DEPTH);
  localparam logic [CD_W-1:0] CD_INIT = CD_W'(LATENCY - 1);

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [4:0]       count_q, count_d;
  q_entry_t         ent_q [DEPTH];
  q_entry_t         ent_d [DEPTH];

  always_comb begin
    full     = (count_q == DEPTH_C);
    pop_vld  = (count_q != 5'd0) && (ent_q[head_q].countdown == '0);
    pop_tag  = ent_q[head_q].tag;
    pop_data = ent_q[head_q].data;

    // All live countdowns tick together; stale slots ticking is harmless
    // because they are overwritten on push before being read.
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      if (ent_q[i].countdown != '0)
        ent_d[i].countdown = ent_q[i].countdown - CD_W'(1);
    end
    if (push_vld) begin
      ent_d[tail_q].tag       = push_tag;
      ent_d[tail_q].data      = push_data;
      ent_d[tail_q].countdown = CD_INIT;
    end

    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop_vld)  head_d = (head_q == LAST) ? '0 : head_q + PTR_W'(1);
    if (push_vld) tail_d = (tail_q == LAST) ? '0 : tail_q + PTR_W'(1);
    case ({push_vld, pop_vld})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload needs no reset: count_q gates every read.
  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: synthesizable tagged memory responder for the proc2mem bus.
// Accepts LOAD/STORE, returns the allocated tag combinationally on
// mem2proc_response, and reports completion (tag + load data) LATENCY edges
// later on registered mem2proc_tag/mem2proc_data.
//   clk, rst            : clock, async active-low reset
//   proc2mem_addr/data  : byte address (bits [1:0] ignored), store data
//   proc2mem_command    : NONE/LOAD/STORE, 2'b11 ignored
//   mem2proc_response   : accepted tag, 0 = rejected / idle
//   mem2proc_tag/data   : completing tag and load data, one cycle wide
// Optional macro MEM_BACKPRESSURE_EN: LFSR-driven random request rejection.
module mem_responder
  import mem_bus_pkg::*;
#(
  parameter int ADDR_BITS   = 12,
  parameter int LATENCY     = 4,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       proc2mem_addr,
  input  logic [DATA_W-1:0] proc2mem_data,
  input  logic [1:0]        proc2mem_command,
  output tag_t              mem2proc_response,
  output logic [DATA_W-1:0] mem2proc_data,
  output tag_t              mem2proc_tag
);
  logic [DATA_W-1:0] unified_memory [2**ADDR_BITS];

  tag_t              next_tag_q, next_tag_d;
  tag_t              tag_q, tag_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic [ADDR_BITS-1:0] mem_idx;
  logic                 addr_oor, cmd_vld, bp_block, accept, mem_we;
  logic [DATA_W-1:0]    push_data;
  logic                 q_full, pop_vld;
  tag_t                 pop_tag;
  logic [DATA_W-1:0]    pop_data;
  logic                 unused_addr_lsb;

  assign unused_addr_lsb = ^proc2mem_addr[1:0];

`ifdef MEM_BACKPRESSURE_EN
  // Fibonacci LFSR, taps 8,6,5,4; free-running, rejects when low bits are 00.
  logic [7:0] lfsr_q, lfsr_d;
  always_comb lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr_q <= 8'hA5;
    else      lfsr_q <= lfsr_d;
  end
  assign bp_block = (lfsr_q[1:0] == 2'b00);
`else
  assign bp_block = 1'b0;
`endif

  always_comb begin
    mem_idx  = proc2mem_addr[ADDR_BITS+1:2];
    addr_oor = (proc2mem_addr >> (ADDR_BITS + 2)) != 32'd0;
    cmd_vld  = (proc2mem_command == BUS_LOAD) || (proc2mem_command == BUS_STORE);
    // Fullness is the pre-edge count: a head completing this edge does not free a slot.
    accept   = cmd_vld && !q_full && !bp_block;
    mem_we   = accept && (proc2mem_command == BUS_STORE) && !addr_oor;

    mem2proc_response = accept ? next_tag_q : tag_t'(0);
    next_tag_d        = accept ? tag_next(next_tag_q) : next_tag_q;

    // Loads snapshot the array now; stores complete with zero data.
    push_data = '0;
    if (proc2mem_command == BUS_LOAD && !addr_oor)
      push_data = unified_memory[mem_idx];

    tag_d  = pop_vld ? pop_tag  : tag_t'(0);
    data_d = pop_vld ? pop_data : '0;
  end

  mem_resp_queue #(
    .DEPTH   (QUEUE_DEPTH),
    .LATENCY (LATENCY)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst),
    .push_vld  (accept),
    .push_tag  (next_tag_q),
    .push_data (push_data),
    .full      (q_full),
    .pop_vld   (pop_vld),
    .pop_tag   (pop_tag),
    .pop_data  (pop_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      next_tag_q <= tag_t'(1);
      tag_q      <= '0;
      data_q     <= '0;
    end else begin
      next_tag_q <= next_tag_d;
      tag_q      <= tag_d;
      data_q     <= data_d;
    end
  end

  // Array contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) unified_memory[mem_idx] <= proc2mem_data;
  end

  assign mem2proc_tag  = tag_q;
  assign mem2proc_data = data_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed self-checking bench for mem_responder
// (default build, ADDR_BITS=12, LATENCY=4, QUEUE_DEPTH=4).
// Inputs change at the falling edge; outputs are sampled 1ns later, so a
// request accepted at the rising edge after drive call N shows its
// completion at drive call N+5.
module tb_mem_responder;
  import mem_bus_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, wdata, rdata;
  logic [1:0]  cmd;
  logic [3:0]  resp, tag;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_BITS(12), .LATENCY(4), .QUEUE_DEPTH(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .proc2mem_addr     (addr),
    .proc2mem_data     (wdata),
    .proc2mem_command  (cmd),
    .mem2proc_response (resp),
    .mem2proc_data     (rdata),
    .mem2proc_tag      (tag)
  );

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", name, obs, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic [3:0] et, input logic [31:0] ed);
    chk({name, " tag"}, {28'd0, tag}, {28'd0, et});
    chk({name, " data"}, rdata, ed);
  endtask

  task automatic drive(input logic [1:0] c, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    cmd = c; addr = a; wdata = d;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(BUS_NONE, 32'd0, 32'd0);
  endtask

  task automatic req(input string name, input logic [1:0] c, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] er);
    drive(c, a, d);
    chk({name, " resp"}, {28'd0, resp}, {28'd0, er});
  endtask

  initial begin
    rst = 1'b0; cmd = BUS_NONE; addr = '0; wdata = '0;
    repeat (2) @(negedge clk);
    #1;
    chk_out("reset", 4'd0, 32'd0);
    chk("reset resp", {28'd0, resp}, 32'd0);
    rst = 1'b1;

    // Store then load the same word; exact completion cycle and width.
    req("t1 st", BUS_STORE, 32'h40, 32'hDEADBEEF, 4'd1);
    idle(4);                       chk_out("t1 early", 4'd0, 32'd0);
    req("t1 ld", BUS_LOAD, 32'h40, 32'd0, 4'd2);
                                   chk_out("t1 st done", 4'd1, 32'd0);
    idle(1);                       chk_out("t1 one cycle", 4'd0, 32'd0);
    idle(4);                       chk_out("t1 ld done", 4'd2, 32'hDEADBEEF);
    idle(1);                       chk_out("t1 after", 4'd0, 32'd0);

    // Back-to-back store/load: the load sees the new value.
    req("t2 st", BUS_STORE, 32'h40, 32'h12345678, 4'd3);
    req("t2 ld", BUS_LOAD, 32'h40, 32'd0, 4'd4);
    idle(4);                       chk_out("t2 st done", 4'd3, 32'd0);
    idle(1);                       chk_out("t2 ld done", 4'd4, 32'h12345678);
    idle(1);                       chk_out("t2 after", 4'd0, 32'd0);

    // Fill the queue; the fifth request is rejected although the head
    // completes at that same edge.
    req("t3 l0", BUS_LOAD, 32'h40, 32'd0, 4'd5);
    req("t3 l1", BUS_LOAD, 32'h40, 32'd0, 4'd6);
    req("t3 l2", BUS_LOAD, 32'h40, 32'd0, 4'd7);
    req("t3 l3", BUS_LOAD, 32'h40, 32'd0, 4'd8);
    req("t3 full", BUS_LOAD, 32'h40, 32'd0, 4'd0);
    req("t3 l5", BUS_LOAD, 32'h40, 32'd0, 4'd9);
                                   chk_out("t3 c5", 4'd5, 32'h12345678);
    idle(1);                       chk_out("t3 c6", 4'd6, 32'h12345678);
    idle(1);                       chk_out("t3 c7", 4'd7, 32'h12345678);
    idle(1);                       chk_out("t3 c8", 4'd8, 32'h12345678);
    idle(1);                       chk_out("t3 gap", 4'd0, 32'd0);
    idle(1);                       chk_out("t3 c9", 4'd9, 32'h12345678);

    // Out-of-range: load returns 0, store is dropped (would alias word 0x10).
    req("t4 ld oor", BUS_LOAD, 32'h0001_0000, 32'd0, 4'd10);
    req("t4 st oor", BUS_STORE, 32'h0001_0040, 32'hFFFF_FFFF, 4'd11);
    req("t4 ld", BUS_LOAD, 32'h40, 32'd0, 4'd12);
    idle(3);                       chk_out("t4 c10", 4'd10, 32'd0);
    idle(1);                       chk_out("t4 c11", 4'd11, 32'd0);
    idle(1);                       chk_out("t4 c12", 4'd12, 32'h12345678);

    // Tag wrap 15 -> 1.
    req("t5 w0", BUS_LOAD, 32'h40, 32'd0, 4'd13);
    req("t5 w1", BUS_LOAD, 32'h40, 32'd0, 4'd14);
    req("t5 w2", BUS_LOAD, 32'h40, 32'd0, 4'd15);
    req("t5 w3", BUS_LOAD, 32'h40, 32'd0, 4'd1);
    idle(1);                       chk_out("t5 quiet", 4'd0, 32'd0);
    idle(1);                       chk_out("t5 c13", 4'd13, 32'h12345678);
    idle(1);                       chk_out("t5 c14", 4'd14, 32'h12345678);
    idle(1);                       chk_out("t5 c15", 4'd15, 32'h12345678);
    idle(1);                       chk_out("t5 c1", 4'd1, 32'h12345678);

    // Reserved command is ignored and does not consume a tag.
    req("t6 rsvd", 2'b11, 32'h40, 32'd0, 4'd0);
    req("t6 ld a", BUS_LOAD, 32'h40, 32'd0, 4'd2);
    req("t6 ld b", BUS_LOAD, 32'h40, 32'd0, 4'd3);
    idle(1);

    // Reset mid-flight discards outstanding entries.
    rst = 1'b0;
    #2;
    chk_out("t7 in reset", 4'd0, 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      idle(1);
      chk_out("t7 no stale", 4'd0, 32'd0);
    end
    req("t7 ld", BUS_LOAD, 32'h40, 32'd0, 4'd1);
    idle(5);                       chk_out("t7 done", 4'd1, 32'h12345678);
    idle(1);                       chk_out("t7 after", 4'd0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
